// File: rtl/scan_decoder.sv
// Registered select-to-one-hot decoder with handshaked direct mode
// and an autonomous scanning mode with dwell and blanking.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int BLANK_CYC  = 1,
  parameter int ACTIVE_LOW = 0,
  localparam int OUT_W     = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   X,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLAST =
    BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [OUT_W-1:0] BLANK =
    (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN_ON,
    S_SCAN_BLANK
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_x;
  logic [SEL_W-1:0]   r_idx;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_dcnt;
  logic [DWELL_W-1:0] r_dwell;
  logic [BW-1:0]      r_bcnt;

  logic [SEL_W-1:0]   w_nidx;
  logic               w_xfer;
  logic               w_step_end;
  logic               w_blank_end;

  // XOR with the blank pattern applies output polarity
  function automatic logic [OUT_W-1:0] f_pat(
    input logic [SEL_W-1:0] n
  );
    logic [OUT_W-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v ^ BLANK;
  endfunction

  assign sel_ready   = en & ~mode & (r_state == S_DIRECT);
  assign w_xfer      = sel_valid & sel_ready;
  assign w_nidx      = r_idx + 1'b1;
  assign w_step_end  = (r_dcnt == r_dwell);
  assign w_blank_end = (r_bcnt == BLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= BLANK;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_dcnt  <= '0;
      r_dwell <= '0;
      r_bcnt  <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (!en) begin
        r_state <= S_IDLE;
        r_x     <= BLANK;
        r_dcnt  <= '0;
        r_bcnt  <= '0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DIRECT: begin
            if (mode) begin
              r_state <= S_SCAN_ON;
              r_idx   <= '0;
              r_x     <= f_pat('0);
              r_dwell <= dwell;
              r_dcnt  <= '0;
            end else if (r_state == S_IDLE) begin
              r_state <= S_DIRECT;
            end else if (w_xfer) begin
              r_x   <= f_pat(sel);
              r_idx <= sel;
            end
          end
          S_SCAN_ON: begin
            if (!mode) begin
              r_state <= S_DIRECT;
              r_x     <= BLANK;
              r_dcnt  <= '0;
            end else if (!w_step_end) begin
              r_dcnt <= r_dcnt + 1'b1;
            end else if (BLANK_CYC != 0) begin
              r_state <= S_SCAN_BLANK;
              r_x     <= BLANK;
              r_bcnt  <= '0;
            end else begin
              r_idx   <= w_nidx;
              r_x     <= f_pat(w_nidx);
              r_wrap  <= (w_nidx == '0);
              r_dwell <= dwell;
              r_dcnt  <= '0;
            end
          end
          S_SCAN_BLANK: begin
            if (!mode) begin
              r_state <= S_DIRECT;
              r_x     <= BLANK;
              r_bcnt  <= '0;
            end else if (!w_blank_end) begin
              r_bcnt <= r_bcnt + 1'b1;
            end else begin
              r_state <= S_SCAN_ON;
              r_idx   <= w_nidx;
              r_x     <= f_pat(w_nidx);
              r_wrap  <= (w_nidx == '0);
              r_dwell <= dwell;
              r_dcnt  <= '0;
              r_bcnt  <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign X    = r_x;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Randomised self-checking bench for scan_decoder against a
// cycle-position model of the direct and scan behaviour.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       sel_valid;
  logic [2:0] sel;
  logic [3:0] sel4;
  logic [7:0] dwell;

  logic [7:0]  x0, x1;
  logic [15:0] x2;
  logic [2:0]  idx0, idx1;
  logic [3:0]  idx2;
  logic        wrap0, wrap1, wrap2;
  logic        rdy0, rdy1, rdy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_decoder #(
    .SEL_W(3), .DWELL_W(8), .BLANK_CYC(1), .ACTIVE_LOW(0)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sel(sel), .sel_valid(sel_valid), .sel_ready(rdy0),
    .dwell(dwell), .X(x0), .idx(idx0), .wrap(wrap0)
  );

  scan_decoder #(
    .SEL_W(3), .DWELL_W(8), .BLANK_CYC(0), .ACTIVE_LOW(0)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sel(sel), .sel_valid(sel_valid), .sel_ready(rdy1),
    .dwell(dwell), .X(x1), .idx(idx1), .wrap(wrap1)
  );

  scan_decoder #(
    .SEL_W(4), .DWELL_W(8), .BLANK_CYC(2), .ACTIVE_LOW(1)
  ) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sel(sel4), .sel_valid(sel_valid), .sel_ready(rdy2),
    .dwell(dwell), .X(x2), .idx(idx2), .wrap(wrap2)
  );

  function automatic logic [7:0] e8(input int pos);
    if (pos < 0) return 8'h00;
    return 8'(1 << pos);
  endfunction

  function automatic logic [15:0] e16(input int pos);
    if (pos < 0) return 16'hFFFF;
    return ~16'(1 << pos);
  endfunction

  // t = cycles since the scan's first output appeared
  function automatic void scan_exp(
    input int t, input int d, input int blank, input int w,
    output int pos, output int ix, output bit wr
  );
    int p;
    int s;
    int ph;
    p   = d + 1 + blank;
    s   = t / p;
    ph  = t % p;
    ix  = s % w;
    pos = (ph <= d) ? ix : -1;
    wr  = (ph == 0) && (s > 0) && (ix == 0);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 1'b0;
    sel_valid = 1'b0; sel = '0; sel4 = '0; dwell = '0;
    tick; tick;
    checks++; if (x0 !== 8'h00) begin errors++;
      $display("FAIL rst_x0 got=%h exp=%h", x0, 8'h00); end
    checks++; if (idx0 !== 3'd0) begin errors++;
      $display("FAIL rst_idx0 got=%0d exp=0", idx0); end
    checks++; if (wrap0 !== 1'b0) begin errors++;
      $display("FAIL rst_wrap0 got=%b exp=0", wrap0); end
    checks++; if (x2 !== 16'hFFFF) begin errors++;
      $display("FAIL rst_x2 got=%h exp=ffff", x2); end
    checks++; if (rdy0 !== 1'b0) begin errors++;
      $display("FAIL rst_rdy0 got=%b exp=0", rdy0); end
    rst = 1'b0; en = 1'b1;
    tick;
    checks++; if (x0 !== 8'h00) begin errors++;
      $display("FAIL en_x0 got=%h exp=00", x0); end
    checks++; if (rdy0 !== 1'b1) begin errors++;
      $display("FAIL en_rdy0 got=%b exp=1", rdy0); end
    checks++; if (rdy2 !== 1'b1) begin errors++;
      $display("FAIL en_rdy2 got=%b exp=1", rdy2); end
  endtask

  task automatic test_direct;
    int last;
    logic [3:0] l4;
    for (int n = 0; n < 8; n++) begin
      sel = 3'(n); sel4 = 4'($urandom); sel_valid = 1'b1;
      l4 = sel4;
      tick;
      checks++; if (x0 !== e8(n)) begin errors++;
        $display("FAIL dir_x0 n=%0d got=%h exp=%h", n, x0, e8(n)); end
      checks++; if (idx0 !== 3'(n)) begin errors++;
        $display("FAIL dir_idx0 got=%0d exp=%0d", idx0, n); end
      checks++; if (x1 !== e8(n)) begin errors++;
        $display("FAIL dir_x1 got=%h exp=%h", x1, e8(n)); end
      checks++; if (x2 !== e16(int'(l4))) begin errors++;
        $display("FAIL dir_x2 got=%h exp=%h", x2, e16(int'(l4))); end
    end
    sel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 3'($urandom);
      tick;
      checks++; if (x0 !== 8'h80) begin errors++;
        $display("FAIL dir_hold got=%h exp=80", x0); end
    end
    last = 7;
    for (int i = 0; i < 24; i++) begin
      sel_valid = 1'($urandom);
      sel = 3'($urandom);
      if (sel_valid) last = int'(sel);
      tick;
      checks++; if (x0 !== e8(last)) begin errors++;
        $display("FAIL dir_rand got=%h exp=%h", x0, e8(last)); end
      checks++; if (idx0 !== 3'(last)) begin errors++;
        $display("FAIL dir_ridx got=%0d exp=%0d", idx0, last); end
    end
    sel4 = 4'd9; sel_valid = 1'b1;
    tick;
    sel_valid = 1'b0;
    checks++; if (x2 !== 16'hFDFF) begin errors++;
      $display("FAIL dir_al9 got=%h exp=fdff", x2); end
    checks++; if (idx2 !== 4'd9) begin errors++;
      $display("FAIL dir_al9_idx got=%0d exp=9", idx2); end
  endtask

  task automatic test_reset_mid;
    sel = 3'd3; sel_valid = 1'b1;
    tick;
    sel_valid = 1'b0;
    checks++; if (x0 !== 8'h08) begin errors++;
      $display("FAIL mid_pre got=%h exp=08", x0); end
    #2 rst = 1'b1;
    #1;
    checks++; if (x0 !== 8'h00) begin errors++;
      $display("FAIL mid_async_x got=%h exp=00", x0); end
    checks++; if (idx0 !== 3'd0) begin errors++;
      $display("FAIL mid_async_idx got=%0d exp=0", idx0); end
    checks++; if (x2 !== 16'hFFFF) begin errors++;
      $display("FAIL mid_async_x2 got=%h exp=ffff", x2); end
    rst = 1'b0;
    tick; tick;
    checks++; if (x0 !== 8'h00) begin errors++;
      $display("FAIL mid_lost got=%h exp=00", x0); end
  endtask

  task automatic test_scan(input int d, input int cycles);
    int p, ix, ix0, wraps, ewraps;
    bit wr;
    wraps = 0; ewraps = 0; ix0 = 0;
    dwell = 8'(d); mode = 1'b1; sel_valid = 1'b1;
    tick;
    for (int t = 0; t < cycles; t++) begin
      scan_exp(t, d, 1, 8, p, ix, wr);
      ix0 = ix;
      ewraps += int'(wr);
      wraps += int'(wrap0);
      checks++; if (x0 !== e8(p)) begin errors++;
        $display("FAIL scan_x0 t=%0d got=%h exp=%h", t, x0, e8(p)); end
      checks++; if (idx0 !== 3'(ix)) begin errors++;
        $display("FAIL scan_idx0 t=%0d got=%0d exp=%0d", t, idx0, ix); end
      checks++; if (wrap0 !== wr) begin errors++;
        $display("FAIL scan_wrap0 t=%0d got=%b exp=%b", t, wrap0, wr); end
      scan_exp(t, d, 0, 8, p, ix, wr);
      checks++; if (x1 !== e8(p)) begin errors++;
        $display("FAIL scan_x1 t=%0d got=%h exp=%h", t, x1, e8(p)); end
      checks++; if (wrap1 !== wr || idx1 !== 3'(ix)) begin errors++;
        $display("FAIL scan_u1 t=%0d got=%b/%0d exp=%b/%0d",
                 t, wrap1, idx1, wr, ix); end
      scan_exp(t, d, 2, 16, p, ix, wr);
      checks++; if (x2 !== e16(p)) begin errors++;
        $display("FAIL scan_x2 t=%0d got=%h exp=%h", t, x2, e16(p)); end
      checks++; if (wrap2 !== wr || idx2 !== 4'(ix)) begin errors++;
        $display("FAIL scan_u2 t=%0d got=%b/%0d exp=%b/%0d",
                 t, wrap2, idx2, wr, ix); end
      checks++; if ({rdy0, rdy1, rdy2} !== 3'b000) begin errors++;
        $display("FAIL scan_rdy got=%b exp=000", {rdy0, rdy1, rdy2}); end
      sel = 3'($urandom); sel4 = 4'($urandom);
      if (t < cycles - 1) tick;
    end
    checks++; if (wraps !== ewraps) begin errors++;
      $display("FAIL scan_wraps got=%0d exp=%0d", wraps, ewraps); end
    mode = 1'b0; sel_valid = 1'b0;
    tick;
    checks++; if (x0 !== 8'h00 || wrap0 !== 1'b0) begin errors++;
      $display("FAIL abort_x got=%h/%b exp=00/0", x0, wrap0); end
    checks++; if (idx0 !== 3'(ix0)) begin errors++;
      $display("FAIL abort_idx got=%0d exp=%0d", idx0, ix0); end
    checks++; if (rdy0 !== 1'b1) begin errors++;
      $display("FAIL abort_rdy got=%b exp=1", rdy0); end
  endtask

  task automatic test_abort;
    int d;
    d = int'($urandom_range(0, 3));
    test_scan(d, 4 * (d + 2) + 1);
    checks++; if (idx0 !== 3'd4) begin errors++;
      $display("FAIL abort_at10 got=%0d exp=4", idx0); end
  endtask

  task automatic test_enable;
    int d, k, p, ix;
    bit wr;
    d = int'($urandom_range(0, 3));
    k = int'($urandom_range(1, 30));
    dwell = 8'(d); mode = 1'b1;
    tick;
    for (int t = 0; t < k; t++) tick;
    scan_exp(k, d, 1, 8, p, ix, wr);
    en = 1'b0;
    tick;
    checks++; if (x0 !== 8'h00 || wrap0 !== 1'b0) begin errors++;
      $display("FAIL en_off_x got=%h/%b exp=00/0", x0, wrap0); end
    checks++; if (idx0 !== 3'(ix)) begin errors++;
      $display("FAIL en_off_idx got=%0d exp=%0d", idx0, ix); end
    checks++; if (x2 !== 16'hFFFF || rdy0 !== 1'b0) begin errors++;
      $display("FAIL en_off_x2 got=%h/%b exp=ffff/0", x2, rdy0); end
    en = 1'b1;
    tick;
    checks++; if (x0 !== 8'h01 || idx0 !== 3'd0) begin errors++;
      $display("FAIL en_restart got=%h/%0d exp=01/0", x0, idx0); end
    mode = 1'b0;
    tick;
    checks++; if (x0 !== 8'h00 || rdy0 !== 1'b1) begin errors++;
      $display("FAIL en_direct got=%h/%b exp=00/1", x0, rdy0); end
  endtask

  task automatic test_mode_priority;
    sel = 3'd6; sel_valid = 1'b1; mode = 1'b1; dwell = 8'd3;
    #1;
    checks++; if (rdy0 !== 1'b0) begin errors++;
      $display("FAIL prio_rdy got=%b exp=0", rdy0); end
    tick;
    checks++; if (x0 !== 8'h01 || idx0 !== 3'd0) begin errors++;
      $display("FAIL prio_scan got=%h/%0d exp=01/0", x0, idx0); end
    sel_valid = 1'b0; mode = 1'b0;
    tick; tick;
    checks++; if (x0 !== 8'h00) begin errors++;
      $display("FAIL prio_nocap got=%h exp=00", x0); end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_reset_mid;
    test_scan(2, 64);
    test_scan(0, 24);
    test_scan(int'($urandom_range(1, 4)), 80);
    test_abort;
    test_enable;
    test_mode_priority;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
